// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: op codes, FSM states and flag bit positions.
// ALU_SEQ_MUL_EN (defined) enables the shift-add multiplier in alu_seq.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADC  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SBC  = 4'd3,
        ALU_NAND = 4'd4,
        ALU_PASS = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_MUL  = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLG_CARRY = 0;
    localparam int FLG_LT    = 1;
    localparam int FLG_Z     = 2;
    localparam int FLG_N     = 3;

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational add/sub/nand/pass unit; arithmetic is done at WIDTH+1 bits.
// Ops without a carry-out of their own pass i_cin through unchanged.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout
);

    logic [WIDTH:0] w_ae;
    logic [WIDTH:0] w_be;
    logic [WIDTH:0] w_bn;
    logic [WIDTH:0] w_ci;
    logic [WIDTH:0] w_sum;
    logic           w_arith;

    assign w_ae = {1'b0, i_a};
    assign w_be = {1'b0, i_b};
    assign w_bn = {1'b0, ~i_b};
    assign w_ci = {{WIDTH{1'b0}}, i_cin};

    always_comb begin
        w_sum   = '0;
        w_arith = 1'b0;
        o_res   = i_a;
        o_cout  = i_cin;
        case (i_op)
            ALU_ADD:  begin w_sum = w_ae + w_be;                    w_arith = 1'b1; end
            ALU_ADC:  begin w_sum = w_ae + w_be + w_ci;             w_arith = 1'b1; end
            ALU_SUB:  begin w_sum = w_ae + w_bn + (WIDTH+1)'(1);    w_arith = 1'b1; end
            ALU_SBC:  begin w_sum = w_ae + w_bn + w_ci;             w_arith = 1'b1; end
            ALU_NAND: o_res = ~(i_a & i_b);
            default:  ;
        endcase
        if (w_arith) begin
            o_res  = w_sum[WIDTH-1:0];
            o_cout = w_sum[WIDTH];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: 1 cycle for most ops, shamt cycles for shifts, WIDTH cycles for MUL (ALU_SEQ_MUL_EN).
// Result is held in DONE until out_ready; requests are only taken in IDLE.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               fl_carry,
    output logic               fl_lt,
    output logic               fl_z
);

    state_e             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [FLG_N-1:0]   r_flags;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sh;
    logic               r_sh_left;

    logic [WIDTH-1:0]   w_comb_res;
    logic               w_comb_cout;
    logic               w_is_shift;
    logic               w_left;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_a_sh1;
    logic               w_a_out1;
    logic               w_acc_busy;
    logic [WIDTH-1:0]   w_acc_res;
    logic               w_acc_c;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic               w_sh_out;
    logic [WIDTH-1:0]   w_busy_res;
    logic               w_busy_c;

`ifdef ALU_SEQ_MUL_EN
    logic               r_is_mul;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] w_prod_nxt;

    // One partial product: add multiplicand into the upper half when the
    // current multiplier bit (LSB) is set, then shift the whole product right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        mul_step = {s, p[WIDTH-1:1]};
    endfunction
`endif

    function automatic logic [FLG_N-1:0] mk_flags(input logic [WIDTH-1:0] res, input logic c);
        mk_flags            = '0;
        mk_flags[FLG_CARRY] = c;
        mk_flags[FLG_LT]    = res[WIDTH-1];
        mk_flags[FLG_Z]     = (res == '0);
    endfunction

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .i_op   (op),
        .i_a    (a),
        .i_b    (b),
        .i_cin  (r_flags[FLG_CARRY]),
        .o_res  (w_comb_res),
        .o_cout (w_comb_cout)
    );

    // Accept-cycle decode; the first shift step happens on the accept edge.
    always_comb begin
        w_is_shift = (op == ALU_SHL) || (op == ALU_SHR);
        w_left     = (op == ALU_SHL);
        w_a_sh1    = w_left ? {a[WIDTH-2:0], 1'b0} : {1'b0, a[WIDTH-1:1]};
        w_a_out1   = w_left ? a[WIDTH-1] : a[0];
`ifdef ALU_SEQ_MUL_EN
        w_is_mul   = (op == ALU_MUL);
`else
        w_is_mul   = 1'b0;
`endif
        w_acc_busy = (w_is_shift && (shamt > SHAMT_W'(1))) || w_is_mul;
        w_acc_res  = w_comb_res;
        w_acc_c    = w_comb_cout;
        if (w_is_shift) begin
            if (shamt == '0) begin
                w_acc_res = a;
                w_acc_c   = r_flags[FLG_CARRY];
            end else begin
                w_acc_res = w_a_sh1;
                w_acc_c   = w_a_out1;
            end
        end
    end

    always_comb begin
        w_sh_nxt   = r_sh_left ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
        w_sh_out   = r_sh_left ? r_sh[WIDTH-1] : r_sh[0];
        w_busy_res = w_sh_nxt;
        w_busy_c   = w_sh_out;
`ifdef ALU_SEQ_MUL_EN
        w_prod_nxt = mul_step(r_prod, r_mcand);
        if (r_is_mul) begin
            w_busy_res = w_prod_nxt[WIDTH-1:0];
            w_busy_c   = |w_prod_nxt[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_sh_left   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_is_mul    <= 1'b0;
            r_prod      <= '0;
            r_mcand     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (w_acc_busy) begin
                            r_state   <= BUSY;
                            r_sh      <= w_a_sh1;
                            r_sh_left <= w_left;
                            r_cnt     <= w_is_mul ? SHAMT_W'(WIDTH-1) : shamt - SHAMT_W'(1);
`ifdef ALU_SEQ_MUL_EN
                            r_is_mul  <= w_is_mul;
                            r_prod    <= mul_step({{WIDTH{1'b0}}, b}, a);
                            r_mcand   <= a;
`endif
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_acc_res;
                            r_flags     <= mk_flags(w_acc_res, w_acc_c);
                        end
                    end
                end
                BUSY: begin
                    r_sh  <= w_sh_nxt;
                    r_cnt <= r_cnt - SHAMT_W'(1);
`ifdef ALU_SEQ_MUL_EN
                    r_prod <= w_prod_nxt;
`endif
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_busy_res;
                        r_flags     <= mk_flags(w_busy_res, w_busy_c);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign fl_carry  = r_flags[FLG_CARRY];
    assign fl_lt     = r_flags[FLG_LT];
    assign fl_z      = r_flags[FLG_Z];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, backpressure, mid-op reset, random ops.
module tb_alu_seq;

    localparam int W  = 8;
    localparam int SW = $clog2(W);
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op_s;
    logic [W-1:0]  a_s;
    logic [W-1:0]  b_s;
    logic [SW-1:0] shamt_s;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          fl_carry;
    logic          fl_lt;
    logic          fl_z;

    int total = 0;
    int bad   = 0;
    int m_res = 0;
    int m_c   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_s),
        .a         (a_s),
        .b         (b_s),
        .shamt     (shamt_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .fl_carry  (fl_carry),
        .fl_lt     (fl_lt),
        .fl_z      (fl_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, carry and latency straight from the op definitions.
    task automatic model(input int t_op, input int t_a, input int t_b, input int t_sh,
                         output int res, output int c, output int lat);
        int s;
        res = t_a; c = m_c; lat = 1;
        case (t_op)
            0: begin s = t_a + t_b;                      res = s & MASK; c = (s >> W) & 1; end
            1: begin s = t_a + t_b + m_c;                res = s & MASK; c = (s >> W) & 1; end
            2: begin s = t_a + ((~t_b) & MASK) + 1;      res = s & MASK; c = (s >> W) & 1; end
            3: begin s = t_a + ((~t_b) & MASK) + m_c;    res = s & MASK; c = (s >> W) & 1; end
            4: res = (~(t_a & t_b)) & MASK;
            6: if (t_sh > 0) begin
                   res = (t_a << t_sh) & MASK; c = (t_a >> (W - t_sh)) & 1; lat = t_sh;
               end
            7: if (t_sh > 0) begin
                   res = t_a >> t_sh; c = (t_a >> (t_sh - 1)) & 1; lat = t_sh;
               end
`ifdef ALU_SEQ_MUL_EN
            8: begin s = t_a * t_b; res = s & MASK; c = ((s >> W) != 0) ? 1 : 0; lat = W; end
`endif
            default: ;
        endcase
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_res"}, 32'(result), m_res);
        chk({tag, "_c"},   32'(fl_carry), m_c);
        chk({tag, "_lt"},  32'(fl_lt), (m_res >> (W - 1)) & 1);
        chk({tag, "_z"},   32'(fl_z), (m_res == 0) ? 1 : 0);
    endtask

    task automatic scramble();
        op_s    = 4'($urandom_range(0, 15));
        a_s     = W'($urandom_range(0, MASK));
        b_s     = W'($urandom_range(0, MASK));
        shamt_s = SW'($urandom_range(0, W - 1));
    endtask

    task automatic run_op(input string tag, input int t_op, input int t_a, input int t_b,
                          input int t_sh, input int hold);
        int er, ec, el, n;
        bit seen;
        model(t_op, t_a, t_b, t_sh, er, ec, el);
        @(negedge clk);
        in_valid = 1'b1; op_s = 4'(t_op); a_s = W'(t_a); b_s = W'(t_b); shamt_s = SW'(t_sh);
        chk({tag, "_rdy_idle"}, 32'(in_ready), 1);
        chk({tag, "_ov_idle"}, 32'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
            else begin
                chk({tag, "_busy_res"}, 32'(result), m_res);
                chk({tag, "_busy_rdy"}, 32'(in_ready), 0);
            end
        end
        chk({tag, "_lat"}, n, el);
        m_res = er; m_c = ec;
        chk_outs(tag);
        chk({tag, "_rdy_done"}, 32'(in_ready), 0);
        repeat (hold) begin
            in_valid = 1'b1;
            scramble();
            @(negedge clk);
            chk({tag, "_bp_ov"}, 32'(out_valid), 1);
            chk({tag, "_bp_rdy"}, 32'(in_ready), 0);
            chk_outs({tag, "_bp"});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk({tag, "_ov_after"}, 32'(out_valid), 0);
        chk({tag, "_rdy_after"}, 32'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_s = '0; a_s = '0; b_s = '0; shamt_s = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 1);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_res", 32'(result), 0);
        chk("rst_flags", {29'd0, fl_carry, fl_lt, fl_z}, 0);
        rst_n = 1'b1;

        run_op("add_ff_01", 0, 'hFF, 'h01, 0, 0);
        run_op("adc_00_00", 1, 'h00, 'h00, 0, 0);
        run_op("sub_05_07", 2, 'h05, 'h07, 0, 0);
        run_op("add_setc", 0, 'hFF, 'h01, 0, 0);
        run_op("sbc_05_05", 3, 'h05, 'h05, 0, 0);
        run_op("shr_81_1", 7, 'h81, 0, 1, 0);
        run_op("shl_81_3", 6, 'h81, 0, 3, 0);
        run_op("shl_81_0", 6, 'h81, 0, 0, 0);
        run_op("shr_c3_7", 7, 'hC3, 0, 7, 0);
        run_op("nand_f0_3c", 4, 'hF0, 'h3C, 0, 0);
        run_op("mul_10_20", 8, 'h10, 'h20, 0, 0);
        run_op("mul_0d_0b", 8, 'h0D, 'h0B, 0, 0);
        run_op("rsvd_12", 12, 'h5A, 'h11, 0, 0);
        run_op("bp_add", 0, 'h7F, 'h01, 0, 5);
        run_op("bp_shl", 6, 'h03, 0, 4, 5);

        // Mid-op reset: leave a nonzero result/lt behind, then abort a long shift.
        run_op("pre_rst_sub", 2, 'h05, 'h07, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; op_s = 4'd6; a_s = W'('hFF); shamt_s = SW'(7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 32'(out_valid), 0);
        chk("midrst_rdy", 32'(in_ready), 1);
        chk("midrst_res", 32'(result), 0);
        chk("midrst_flags", {29'd0, fl_carry, fl_lt, fl_z}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_res = 0; m_c = 0;
        @(negedge clk);
        chk("postrst_rdy", 32'(in_ready), 1);
        run_op("postrst_add", 0, 'h12, 'h34, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op("rnd", $urandom_range(0, 15), $urandom_range(0, MASK), $urandom_range(0, MASK),
                   $urandom_range(0, W - 1), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
